// File: rtl/cosim_commit_fifo.sv
// Commit-capture queue feeding the co-simulation scoreboard.
// Gated on the first START_PC commit; overflow is counted and may freeze capture.
package cosim_commit_pkg;
  typedef struct packed {
    logic [31:0] seq;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        rd_we;
    logic [4:0]  frd;
    logic        frd_we;
    logic [63:0] data;
    logic [63:0] rs1_data;
    logic        excep;
    logic [63:0] cause;
  } commit_t;
endpackage

module cosim_commit_fifo
  import cosim_commit_pkg::*;
#(
  parameter int          DEPTH         = 16,
  parameter logic [63:0] START_PC      = 64'h8000_0000,
  parameter bit          FREEZE_ON_OVF = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [63:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic [4:0]               in_rd,
  input  logic                     in_rd_we,
  input  logic [4:0]               in_frd,
  input  logic                     in_frd_we,
  input  logic [63:0]              in_data,
  input  logic [63:0]              in_rs1_data,
  input  logic                     in_excep,
  input  logic [63:0]              in_cause,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output commit_t                  out_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic                     capturing
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    WAIT_START,
    RUN,
    FROZEN
  } state_t;

  state_t        state;
  commit_t       mem [DEPTH];
  commit_t       in_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [31:0]   seq;
  logic          full;
  logic          empty;
  logic          start_hit;
  logic          live;
  logic          push;
  logic          pop;
  logic          drop;

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign start_hit = (state == WAIT_START) && in_valid && (in_pc == START_PC);
  assign live      = start_hit || ((state == RUN) && in_valid);
  assign pop       = !empty && out_ready;
  assign push      = live && (!full || pop);
  assign drop      = (state == RUN) && in_valid && full && !pop;

  // x0 writes are architecturally invisible, so never report them
  always_comb begin
    in_entry = '{
      seq:      seq,
      pc:       in_pc,
      instr:    in_instr,
      rd:       in_rd,
      rd_we:    in_rd_we && (in_rd != 5'd0),
      frd:      in_frd,
      frd_we:   in_frd_we,
      data:     in_data,
      rs1_data: in_rs1_data,
      excep:    in_excep,
      cause:    in_cause
    };
  end

  always_ff @(posedge clk) begin
    if (rst && push && !flush) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= WAIT_START;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      seq       <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      capturing <= 1'b0;
    end else begin
      capturing <= (state == RUN);
      if (start_hit) begin
        state <= RUN;
      end else if (drop && FREEZE_ON_OVF) begin
        state <= FROZEN;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
      // flush wins over any push/pop in the same cycle; seq is not consumed
      if (flush) begin
        cnt    <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          seq    <= seq + 32'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  assign out_valid = !empty;
  assign out_entry = mem[rd_ptr];
  assign count     = cnt;

endmodule

// File: tb/tb_cosim_commit_fifo.sv
// Directed bench for cosim_commit_fifo at DEPTH=4 with freeze-on-overflow.
module tb_cosim_commit_fifo;
  import cosim_commit_pkg::*;

  localparam logic [63:0] SPC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [4:0]  in_frd;
  logic        in_frd_we;
  logic [63:0] in_data;
  logic [63:0] in_rs1_data;
  logic        in_excep;
  logic [63:0] in_cause;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  commit_t     out_entry;
  logic [2:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        capturing;

  int errors = 0;
  int checks = 0;

  cosim_commit_fifo #(
    .DEPTH(4),
    .START_PC(SPC),
    .FREEZE_ON_OVF(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_pc(in_pc),
    .in_instr(in_instr),
    .in_rd(in_rd),
    .in_rd_we(in_rd_we),
    .in_frd(in_frd),
    .in_frd_we(in_frd_we),
    .in_data(in_data),
    .in_rs1_data(in_rs1_data),
    .in_excep(in_excep),
    .in_cause(in_cause),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_entry(out_entry),
    .count(count),
    .overflow(overflow),
    .drop_cnt(drop_cnt),
    .capturing(capturing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic        rdy;
    int          cnt;
    logic        ovf;
    int          dcnt;
    logic        cap;
    int          hseq;
    logic [63:0] hpc;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic v, logic [63:0] pc, logic rdy,
                              int cnt, logic ovf, int dcnt, logic cap,
                              int hseq, logic [63:0] hpc);
    vec_t r;
    r.v = v; r.pc = pc; r.rdy = rdy; r.cnt = cnt; r.ovf = ovf;
    r.dcnt = dcnt; r.cap = cap; r.hseq = hseq; r.hpc = hpc;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(logic v, logic [63:0] pc);
    in_valid    = v;
    in_pc       = pc;
    in_instr    = pc[31:0] + 32'h13;
    in_rd       = 5'd5;
    in_rd_we    = 1'b1;
    in_frd      = 5'd0;
    in_frd_we   = 1'b0;
    in_data     = ~pc;
    in_rs1_data = pc + 64'd8;
    in_excep    = 1'b0;
    in_cause    = 64'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    commit(1'b0, 64'd0);
    out_ready = 1'b0;
    flush = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  int exp_seq;

  initial begin
    rst = 1'b1;
    do_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cap", 64'(capturing), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    // gating, drain, overflow with freeze, drain after freeze
    tbl[0]  = mk(1, 64'h1000,      0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 64'h1004,      0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 64'h1008,      0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 64'h100c,      0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 64'h1010,      0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 64'h8000_0000, 0, 1, 0, 0, 0, 0, 64'h8000_0000);
    tbl[6]  = mk(1, 64'h8000_0004, 0, 2, 0, 0, 1, 0, 64'h8000_0000);
    tbl[7]  = mk(0, 64'h0,         0, 2, 0, 0, 1, 0, 64'h8000_0000);
    tbl[8]  = mk(0, 64'h0,         1, 1, 0, 0, 1, 1, 64'h8000_0004);
    tbl[9]  = mk(0, 64'h0,         1, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(1, 64'h8000_0008, 0, 1, 0, 0, 1, 2, 64'h8000_0008);
    tbl[11] = mk(1, 64'h8000_000c, 0, 2, 0, 0, 1, 2, 64'h8000_0008);
    tbl[12] = mk(1, 64'h8000_0010, 0, 3, 0, 0, 1, 2, 64'h8000_0008);
    tbl[13] = mk(1, 64'h8000_0014, 0, 4, 0, 0, 1, 2, 64'h8000_0008);
    tbl[14] = mk(1, 64'h8000_0018, 0, 4, 1, 1, 1, 2, 64'h8000_0008);
    tbl[15] = mk(1, 64'h8000_001c, 0, 4, 1, 1, 0, 2, 64'h8000_0008);
    tbl[16] = mk(1, 64'h8000_0020, 1, 3, 1, 1, 0, 3, 64'h8000_000c);
    tbl[17] = mk(1, 64'h8000_0024, 1, 2, 1, 1, 0, 4, 64'h8000_0010);
    tbl[18] = mk(1, 64'h8000_0028, 1, 1, 1, 1, 0, 5, 64'h8000_0014);
    tbl[19] = mk(1, 64'h8000_002c, 1, 0, 1, 1, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      commit(tbl[i].v, tbl[i].pc);
      out_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("t%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("t%0d_valid", i), 64'(out_valid), 64'(tbl[i].cnt != 0));
      chk($sformatf("t%0d_ovf", i), 64'(overflow), 64'(tbl[i].ovf));
      chk($sformatf("t%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].dcnt));
      chk($sformatf("t%0d_cap", i), 64'(capturing), 64'(tbl[i].cap));
      if (tbl[i].cnt != 0) begin
        chk($sformatf("t%0d_seq", i), 64'(out_entry.seq), 64'(tbl[i].hseq));
        chk($sformatf("t%0d_pc", i), out_entry.pc, tbl[i].hpc);
      end
    end

    // reset clears sticky overflow state
    do_reset();
    chk("rst2_ovf", 64'(overflow), 64'd0);
    chk("rst2_drop", 64'(drop_cnt), 64'd0);

    // back-to-back streaming with ready held high
    out_ready = 1'b1;
    exp_seq = 0;
    for (int i = 0; i < 100; i++) begin
      commit(1'b1, SPC + 64'(4 * i));
      cyc();
      chk("stream_cnt_le1", 64'(count <= 3'd1), 64'd1);
      if (out_valid) begin
        chk("stream_seq", 64'(out_entry.seq), 64'(exp_seq));
        exp_seq++;
      end
    end
    commit(1'b0, 64'd0);
    cyc();
    chk("stream_delivered", 64'(exp_seq), 64'd100);
    chk("stream_empty", 64'(count), 64'd0);
    chk("stream_ovf", 64'(overflow), 64'd0);

    // full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      commit(1'b1, SPC + 64'(4 * i));
      cyc();
    end
    chk("full_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      commit(1'b1, SPC + 64'(16 + 4 * k));
      cyc();
      chk("pp_count", 64'(count), 64'd4);
      chk("pp_head", 64'(out_entry.seq), 64'(k));
    end
    commit(1'b0, 64'd0);
    for (int k = 10; k < 14; k++) begin
      chk("pp_drain_seq", 64'(out_entry.seq), 64'(k));
      cyc();
    end
    chk("pp_empty", 64'(count), 64'd0);
    chk("pp_ovf", 64'(overflow), 64'd0);
    chk("pp_drop", 64'(drop_cnt), 64'd0);

    // flush with a coincident push; seq 14..16 buffered then discarded
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      commit(1'b1, SPC + 64'h100 + 64'(4 * i));
      cyc();
    end
    chk("fl_pre_count", 64'(count), 64'd3);
    flush = 1'b1;
    commit(1'b1, SPC + 64'h200);
    cyc();
    flush = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    commit(1'b1, SPC + 64'h204);
    cyc();
    chk("fl_next_seq", 64'(out_entry.seq), 64'd17);
    chk("fl_next_pc", out_entry.pc, SPC + 64'h204);

    // one-edge reset with entries buffered and a commit pending
    rst = 1'b0;
    commit(1'b1, SPC + 64'h208);
    cyc();
    rst = 1'b1;
    commit(1'b0, 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_cap", 64'(capturing), 64'd0);
    commit(1'b1, 64'h1000);
    cyc();
    chk("mrst_wait", 64'(count), 64'd0);
    commit(1'b1, SPC);
    cyc();
    chk("mrst_seq0", 64'(out_entry.seq), 64'd0);
    chk("mrst_rdwe", 64'(out_entry.rd_we), 64'd1);

    // trapped commit, rd_we must be squashed for rd=x0
    commit(1'b1, SPC + 64'h4);
    in_excep    = 1'b1;
    in_cause    = 64'h8000_0000_0000_0007;
    in_rd       = 5'd0;
    in_rd_we    = 1'b1;
    in_frd      = 5'd3;
    in_frd_we   = 1'b1;
    in_instr    = 32'h3020_0073;
    in_data     = 64'hdead_beef_0123_4567;
    in_rs1_data = 64'h0200_bff8;
    cyc();
    chk("ex_count", 64'(count), 64'd2);
    commit(1'b0, 64'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("ex_seq", 64'(out_entry.seq), 64'd1);
    chk("ex_pc", out_entry.pc, SPC + 64'h4);
    chk("ex_excep", 64'(out_entry.excep), 64'd1);
    chk("ex_cause", out_entry.cause, 64'h8000_0000_0000_0007);
    chk("ex_rd", 64'(out_entry.rd), 64'd0);
    chk("ex_rd_we", 64'(out_entry.rd_we), 64'd0);
    chk("ex_frd", 64'(out_entry.frd), 64'd3);
    chk("ex_frd_we", 64'(out_entry.frd_we), 64'd1);
    chk("ex_instr", 64'(out_entry.instr), 64'h3020_0073);
    chk("ex_data", out_entry.data, 64'hdead_beef_0123_4567);
    chk("ex_rs1", out_entry.rs1_data, 64'h0200_bff8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cosim_commit_fifo.md
# cosim_commit_fifo

Synthesizable-friendly commit-capture queue between the Lagarto writeback/commit stage and the Spike co-simulation scoreboard. Samples every retired instruction or trapped instruction, tags it with a sequence number and buffers it. Presents entries to the scoreboard over a valid/ready handshake, so the scoreboard can consume at its own pace without ever stalling the core. Capture is gated until the core first commits at the compare-start PC; overflow is detected, counted and optionally freezes capture.

## Interface
- DEPTH, 16: number of entries; must be a power of 2, at least 2.
- START_PC, 64'h80000000: capture begins with the first commit whose sign-extended PC equals this value.
- FREEZE_ON_OVF, 1: 1 stops all further capture after the first overflow; 0 keeps capturing.

- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  commit event this cycle, driven by the core as commit && !stall_exe, or commit && exception
- in_pc  in  64  sign-extended commit PC
- in_instr  in  32  original instruction word
- in_rd / in_rd_we  in  5/1  integer destination and its write enable; rd_we is qualified with rd != 0 on capture
- in_frd / in_frd_we  in  5/1  FP destination and its write enable
- in_data  in  64  writeback data
- in_rs1_data  in  64  rs1 operand value, used by the scoreboard for MMIO/mtime detection
- in_excep  in  1  exception or interrupt taken on this commit
- in_cause  in  64  mcause value; bit 63 marks an interrupt
- flush  in  1  discard all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  scoreboard accepts the head entry
- out_entry  out  all of the above fields plus a 32-bit seq number  head entry
- count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky; set when an event is dropped
- drop_cnt  out  16  saturating count of dropped events
- capturing  out  1  FSM is in the RUN state

## Operation
- FSM states:
  - WAIT_START → RUN when in_valid && in_pc == START_PC. That event is itself captured.
  - RUN → FROZEN on a drop when FREEZE_ON_OVF=1.
  - FROZEN is left only by reset.
  - flush does not change the FSM state.
- Push: in_valid in RUN and not full. Also allowed when full if a pop happens in the same cycle.
- Pop: out_valid && out_ready.
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. count is tracked separately, so full is count == DEPTH and empty is count == 0.
- Drop: in_valid in RUN while full and no pop.
  - The entry is not written.
  - overflow is set.
  - drop_cnt increments and saturates at 16'hFFFF.
- seq:
  - Starts at 0 and is assigned at push.
  - Increments only on an accepted push and wraps from 2^32-1 to 0.
  - Dropped events do not consume a seq value, so the scoreboard detects a gap using overflow.
- in_valid in WAIT_START or FROZEN is ignored and not counted as a drop.
- flush:
  - Sets count to 0 and sets rd_ptr = wr_ptr.
  - A push or pop in the same cycle is discarded.
  - seq, overflow and drop_cnt are retained.
- out_entry is the head entry, read combinationally from storage at rd_ptr. It is don't-care when out_valid is 0, but must be stable while out_valid && !out_ready.

## Timing
- Reset (rst=0 at a clk edge) sets:
  - state = WAIT_START, pointers = 0, count = 0, seq = 0.
  - overflow = 0, drop_cnt = 0.
  - out_valid = 0, capturing = 0.
  - Storage contents are not reset.
- Reset asserted mid-stream discards all entries in that cycle, and no push occurs.
- Latency: an event pushed at edge N is visible on out_valid/out_entry after edge N. Minimum latency is 1 cycle; there is no bypass.
- Throughput: one push and one pop per cycle, sustained indefinitely at any occupancy.
- count update per cycle: count + push − pop, evaluated after the drop decision.
- The FSM transition to RUN and the push of the START_PC event happen at the same edge. capturing rises one cycle later.
- On a drop in RUN with FREEZE_ON_OVF=1, FROZEN is entered at that edge. Already-buffered entries still drain.

## Test plan
- Gating: 5 commits with PCs 0x1000..0x1010, then commits at 0x80000000 and 0x80000004. Required: exactly 2 entries with seq 0 and 1, the first with pc=0x80000000; out_valid rises 1 cycle after the 0x80000000 commit.
- Back-to-back streaming with DEPTH=4 and out_ready=1 held: 100 consecutive commits. Required: count never exceeds 1, seq 0..99 delivered in order, overflow=0.
- Overflow with freeze: DEPTH=4, out_ready=0, 6 commits. Required:
  - count=4 and overflow=1.
  - drop_cnt=1 after the 5th commit, since the FSM is FROZEN and the 6th is ignored.
  - After raising out_ready, seq 0..3 drain; later commits are not captured.
- Full with simultaneous push and pop: fill DEPTH=4, then assert in_valid and out_ready together for 10 cycles. Required: count stays 4, no drop, seq continues 4..13.
- Flush and reset: with 3 entries buffered, pulse flush together with in_valid. Required: count=0 next cycle, that event is lost, and the next push gets the next seq. Then assert rst=0 for one edge while count>0. Required: state=WAIT_START, count=0, overflow=0, drop_cnt=0, seq=0.
- Exception entry: a trapped commit with in_excep=1, in_cause=64'h8000000000000007, in_rd_we=1, in_rd=0. Required: the fields are captured verbatim except rd_we, which is captured as 0.
